// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_stage_ctrl                                             |
// | Description : MEM-stage data-memory access controller. Latches a         |
// |               load/store from EX/MEM, runs a req/ack handshake with an   |
// |               optional timeout, stalls the pipeline until the access     |
// |               completes and presents load data to MEM/WB.                |
// | Options     : define MEM_ALIGN_CHECK_EN to reject word-misaligned        |
// |               accesses (misalign_o pulse, no memory request).            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] ALUresult_i,
  input  logic [DATA_W-1:0] RDdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic              bus_err_o,
  output logic              misalign_o
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit so a
  // disabled timeout (TIMEOUT == 0) still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
  localparam logic c_to_en = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
  logic                w_mem_op;

  assign w_mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic w_misaligned;
  assign w_misaligned = (ALUresult_i[1:0] != 2'b00);
  assign misalign_o   = misalign_q;
`else
  assign misalign_o   = 1'b0;
`endif

  // Next-state and next-output logic; all registers hold unless told otherwise.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_mem_op) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (w_misaligned) begin
            // Rejected before reaching memory; DONE lets EX/MEM advance.
            misalign_d = 1'b1;
            state_d    = ST_DONE;
          end else
`endif
          begin
            addr_d  = ALUresult_i;
            wdata_d = RDdata_i;
            we_d    = MemWrite_i;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack_i) begin
          // Ack wins over a simultaneous timeout expiry.
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) rdata_d = mem_rdata_i;
        end else if (c_to_en && (cnt_q == c_cnt_last)) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          if (!we_q) rdata_d = '1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // EX/MEM still holds the finished instruction here, so never restart.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign stall_o     = ((state_q == ST_IDLE) && w_mem_op) || (state_q == ST_ACCESS);
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign MemData_o   = rdata_q;
  assign bus_err_o   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_stage_ctrl                                          |
// | Description : Self-checking bench for mem_stage_ctrl. A transaction-     |
// |               level model schedules the expected outputs of every cycle  |
// |               and a negedge process compares them against the DUT.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_stage_ctrl;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [DW-1:0] ALUresult_i = '0, RDdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_req_o, mem_we_o, stall_o, bus_err_o, misalign_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o, MemData_o;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUresult_i(ALUresult_i), .RDdata_i(RDdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .MemData_o(MemData_o),
    .bus_err_o(bus_err_o), .misalign_o(misalign_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: what memory-side registers and load result hold.
  logic          m_we = 1'b0;
  logic [DW-1:0] m_addr = '0, m_wdata = '0, m_data = '0;

  // Expected outputs for the current cycle.
  bit            chk = 1'b0;
  logic          e_req, e_we, e_stall, e_err, e_mis;
  logic [DW-1:0] e_addr, e_wdata, e_data;

  // Per-transaction activity counters.
  int cnt_stall = 0, cnt_req = 0, cnt_err = 0, cnt_mis = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle outputs are defined.
  always @(negedge clk) begin
    if (chk) begin
      check("mem_req_o",   {31'b0, mem_req_o},  {31'b0, e_req});
      check("mem_we_o",    {31'b0, mem_we_o},   {31'b0, e_we});
      check("mem_addr_o",  mem_addr_o,          e_addr);
      check("mem_wdata_o", mem_wdata_o,         e_wdata);
      check("stall_o",     {31'b0, stall_o},    {31'b0, e_stall});
      check("MemData_o",   MemData_o,           e_data);
      check("bus_err_o",   {31'b0, bus_err_o},  {31'b0, e_err});
      check("misalign_o",  {31'b0, misalign_o}, {31'b0, e_mis});
      cnt_stall += int'(stall_o);
      cnt_req   += int'(mem_req_o);
      cnt_err   += int'(bus_err_o);
      cnt_mis   += int'(misalign_o);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic req, input logic stall, input logic err, input logic mis);
    e_req   = req;   e_we    = m_we;   e_addr = m_addr; e_wdata = m_wdata;
    e_stall = stall; e_data  = m_data; e_err  = err;    e_mis   = mis;
  endtask

  task automatic clear_counts();
    cnt_stall = 0; cnt_req = 0; cnt_err = 0; cnt_mis = 0;
  endtask

  task automatic idle_cycle(input logic stray_ack);
    next_cycle();
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    mem_ack_i = stray_ack; mem_rdata_i = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One access: ack_at = ACCESS cycle (1-based) carrying the ack, 0 = never.
  task automatic access(input logic rd, input logic wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input int ack_at,
                        input logic [DW-1:0] rdata, input logic late_ack);
    int  n_acc;
    bit  timed_out;
    timed_out = !(ack_at > 0 && ack_at <= TO);
    n_acc     = timed_out ? TO : ack_at;
    clear_counts();
    // IDLE cycle presenting the request
    next_cycle();
    MemRead_i = rd; MemWrite_i = wr; ALUresult_i = addr; RDdata_i = wdata;
    mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    m_we = wr; m_addr = addr; m_wdata = wdata;
    // ACCESS cycles
    for (int c = 1; c <= n_acc; c++) begin
      next_cycle();
      mem_ack_i   = (c == ack_at);
      mem_rdata_i = (c == ack_at) ? rdata : DW'($urandom);
      set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    end
    if (!wr) m_data = timed_out ? '1 : rdata;
    // DONE cycle: instruction still held, outputs settled
    next_cycle();
    mem_ack_i = late_ack; mem_rdata_i = 32'hDEAD_BEEF;
    set_exp(1'b0, 1'b0, timed_out, 1'b0);
    // pipeline advances to a non-memory instruction
    idle_cycle(1'b0);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic misaligned_load(input logic [DW-1:0] addr);
    clear_counts();
    next_cycle();
    MemRead_i = 1'b1; MemWrite_i = 1'b0; ALUresult_i = addr; mem_ack_i = 1'b0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_exp(1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle(1'b0);
  endtask
`endif

  initial begin
    // Reset
    rst_i = 1'b1;
    next_cycle();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    chk = 1'b1;
    next_cycle();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    idle_cycle(1'b1);   // stray ack in IDLE is ignored
    idle_cycle(1'b0);

    // Load, ack in third ACCESS cycle
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, 1'b0);
    check("load_stall_cycles", DW'(cnt_stall), 32'd4);
    check("load_req_cycles",   DW'(cnt_req),   32'd3);
    check("load_data",         MemData_o,      32'h1234_5678);

    // Store, ack in first ACCESS cycle
    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h5555_5555, 1'b0);
    check("store_stall_cycles", DW'(cnt_stall), 32'd2);
    check("store_keeps_data",   MemData_o,      32'h1234_5678);

    // Load that never gets acked; late ack in DONE must be ignored
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b1);
    check("timeout_req_cycles", DW'(cnt_req), 32'd16);
    check("timeout_err_pulses", DW'(cnt_err), 32'd1);
    check("timeout_data",       MemData_o,    32'hFFFF_FFFF);

    // Ack on the very cycle the timeout would expire
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 16, 32'h0BAD_F00D, 1'b0);
    check("edge_err_pulses", DW'(cnt_err), 32'd0);
    check("edge_data",       MemData_o,    32'h0BAD_F00D);

    // Read and write both requested: store wins
    access(1'b1, 1'b1, 32'h0000_0080, 32'h0000_55AA, 2, 32'h7777_7777, 1'b0);
    check("both_keeps_data", MemData_o, 32'h0BAD_F00D);

    // Reset in the second ACCESS cycle, then a late ack
    next_cycle();
    MemRead_i = 1'b1; ALUresult_i = 32'h0000_0100; mem_ack_i = 1'b0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    m_we = 1'b0; m_addr = 32'h0000_0100; m_wdata = RDdata_i;
    next_cycle();
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    rst_i = 1'b1;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    rst_i = 1'b0; MemRead_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hABCD_EF01;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_data = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b0);
    check("reset_clears_data", MemData_o, 32'h0);

    // Recovery after reset
    access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 32'hA5A5_0001, 1'b0);
    check("recover_data", MemData_o, 32'hA5A5_0001);

`ifdef MEM_ALIGN_CHECK_EN
    misaligned_load(32'h0000_0006);
    check("misalign_req_cycles",   DW'(cnt_req),   32'd0);
    check("misalign_pulses",       DW'(cnt_mis),   32'd1);
    check("misalign_stall_cycles", DW'(cnt_stall), 32'd1);
    check("misalign_keeps_data",   MemData_o,      32'hA5A5_0001);
`endif

    idle_cycle(1'b0);
    next_cycle();
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
